// File: rtl/cdb_broadcast_2way_pkg.sv
// Types shared by the CDB transmitter and every CDB consumer (ROB, RS, map table).
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef CDB_WIDTH
`define CDB_WIDTH 2
`endif

package sys_defs;

    localparam int CDB_ROB_W  = $clog2(`ROB_SIZE);
    localparam int CDB_PREG_W = 6;
    localparam int CDB_XLEN   = 32;
    localparam int CDB_SLOTS  = `CDB_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [CDB_ROB_W-1:0]  rob_idx;
        logic [CDB_PREG_W-1:0] dest_preg;
        logic [CDB_XLEN-1:0]   value;
    } CDB_PACKET;

    typedef struct packed {
        logic [CDB_ROB_W-1:0]  rob_idx;
        logic [CDB_PREG_W-1:0] dest_preg;
        logic [CDB_XLEN-1:0]   value;
    } FU_RESULT;

endpackage

// File: rtl/cdb_broadcast_2way_rr_pick2.sv
// Circular two-of-N picker: first and second set req bits scanning upward from ptr.
// Purely combinational, zero latency; no backpressure (callers gate with their own state).
module rr_pick2 #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx0,
    output logic             v0,
    output logic [PTR_W-1:0] idx1,
    output logic             v1,
    output logic [N-1:0]     grant
);

    localparam int CW = PTR_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        v0    = 1'b0;
        v1    = 1'b0;
        idx0  = '0;
        idx1  = '0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k folded back into 0..N-1 without a divider
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (req[cand[PTR_W-1:0]]) begin
                if (!v0) begin
                    v0   = 1'b1;
                    idx0 = cand[PTR_W-1:0];
                    grant[cand[PTR_W-1:0]] = 1'b1;
                end else if (!v1) begin
                    v1   = 1'b1;
                    idx1 = cand[PTR_W-1:0];
                    grant[cand[PTR_W-1:0]] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_broadcast_2way.sv
// 2-wide CDB transmitter: per-FU 1-entry result latches, round-robin broadcast of up to 2 per cycle.
// Latency: result captured at edge t is on the CDB during cycle t+1.
// Backpressure: fu_ready low while a latch is held and not granted, during squash and during reset.
module cdb_broadcast_2way
    import sys_defs::*;
#(
    parameter int NUM_FU    = 4,
    parameter int ROB_IDX_W = CDB_ROB_W,
    parameter int PREG_W    = CDB_PREG_W,
    parameter int XLEN      = CDB_XLEN
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU-1:0][ROB_IDX_W-1:0] fu_rob_idx,
    input  logic [NUM_FU-1:0][PREG_W-1:0]    fu_dest_preg,
    input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
    output logic [NUM_FU-1:0]                fu_ready,
    output CDB_PACKET [1:0]                  CDB_packet_out
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] held_q;
    FU_RESULT          lat_q [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr_q;

    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] capture;
    logic [PTR_W-1:0]  idx0, idx1, last_idx, rr_ptr_nxt;
    logic              v0, v1;

    rr_pick2 #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (held_q),
        .ptr   (rr_ptr_q),
        .idx0  (idx0),
        .v0    (v0),
        .idx1  (idx1),
        .v1    (v1),
        .grant (grant)
    );

    // A granted latch drains on this edge, so it can take a new result on the same edge.
    assign fu_ready = {NUM_FU{~reset & ~squash}} & (~held_q | grant);
    assign capture  = fu_valid & fu_ready;

    assign last_idx   = v1 ? idx1 : idx0;
    assign rr_ptr_nxt = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;

    always_comb begin
        CDB_packet_out = '0;

        CDB_packet_out[0].valid     = v0 & ~squash & ~reset;
        CDB_packet_out[0].rob_idx   = lat_q[idx0].rob_idx;
        CDB_packet_out[0].dest_preg = lat_q[idx0].dest_preg;
        CDB_packet_out[0].value     = lat_q[idx0].value;

        CDB_packet_out[1].valid     = v1 & ~squash & ~reset;
        CDB_packet_out[1].rob_idx   = lat_q[idx1].rob_idx;
        CDB_packet_out[1].dest_preg = lat_q[idx1].dest_preg;
        CDB_packet_out[1].value     = lat_q[idx1].value;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q   <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                lat_q[i] <= '0;
            end
        end else if (squash) begin
            held_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (capture[i]) begin
                    held_q[i]          <= 1'b1;
                    lat_q[i].rob_idx   <= fu_rob_idx[i];
                    lat_q[i].dest_preg <= fu_dest_preg[i];
                    lat_q[i].value     <= fu_value[i];
                end else if (grant[i]) begin
                    held_q[i] <= 1'b0;
                end
            end
            if (v0) begin
                rr_ptr_q <= rr_ptr_nxt;
            end
        end
    end

    logic dup_tag;

    always_comb begin
        dup_tag = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = i + 1; j < NUM_FU; j++) begin
                if (held_q[i] && held_q[j] && (lat_q[i].rob_idx == lat_q[j].rob_idx)) begin
                    dup_tag = 1'b1;
                end
            end
        end
    end

    // Two in-flight results with one ROB tag means an upstream tagging bug.
    a_unique_tag : assert property (@(posedge clock) disable iff (reset) !dup_tag);
    a_slot_order : assert property (@(posedge clock) disable iff (reset)
                                    !(CDB_packet_out[1].valid && !CDB_packet_out[0].valid));

endmodule
